// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0013;
  localparam int unsigned DEFAULT_ADDR_W   = 10;
  localparam int unsigned DEFAULT_DEPTH    = 4;
  localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO: DEPTH entries, single-cycle flush, occupancy count output.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 42
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Flush wins over push and pop; a push into a full queue needs a same-cycle pop.
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;
  assign w_push = i_push && !i_flush && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding memory read, prefetch queue, redirect flush.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned       DEPTH    = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
);

  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = 32 + ADDR_W;

  fetch_state_e        r_state;
  fetch_state_e        w_state_nxt;
  logic [ADDR_W-1:0]   r_fetch_pc;
  logic [ADDR_W-1:0]   w_fetch_pc_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                r_req;
  logic [ADDR_W-1:0]   w_addr_inc;
  logic [ADDR_W-1:0]   w_redirect_pc;
  logic                w_enq;
  logic                w_deq;
  logic [CNT_W-1:0]    w_count;
  logic [CNT_W-1:0]    w_cnt_after;
  logic                w_head_valid;
  logic [ENTRY_W-1:0]  w_head;

  assign w_addr_inc    = r_addr + ADDR_W'(4);
  assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);

  // A redirect kills both the incoming response and any dequeue this cycle.
  assign w_enq       = (r_state == ST_REQ) && imem_ack && !redirect_valid;
  assign w_deq       = inst_ready && w_head_valid && !redirect_valid;
  assign w_cnt_after = w_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= '0;
      r_req      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_addr     <= w_addr_nxt;
      r_req      <= (w_state_nxt != ST_IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_addr_nxt     = r_addr;
    unique case (r_state)
      ST_IDLE: begin
        if (!redirect_valid && (w_count < CNT_W'(DEPTH))) begin
          w_state_nxt = ST_REQ;
          w_addr_nxt  = r_fetch_pc;
        end
      end
      ST_REQ: begin
        if (redirect_valid) begin
          w_state_nxt = imem_ack ? ST_IDLE : ST_DROP;
        end else if (imem_ack) begin
          w_fetch_pc_nxt = w_addr_inc;
          // Chain the next read only if its data will have a free slot.
          if (w_cnt_after < CNT_W'(DEPTH)) w_addr_nxt = w_addr_inc;
          else                             w_state_nxt = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (imem_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (redirect_valid) w_fetch_pc_nxt = w_redirect_pc;
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_data  ({imem_rdata, r_addr}),
    .i_pop   (w_deq),
    .o_valid (w_head_valid),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign inst_valid = w_head_valid;
  assign inst       = w_head_valid ? w_head[ENTRY_W-1 -: 32] : NOP;
  assign inst_pc    = w_head_valid ? w_head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;

  localparam int unsigned AW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP_W = 32'h0000_0013;

  logic          clk;
  logic          reset;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          inst_valid;
  logic [31:0]   inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready;

  fetch_unit #(
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .RESET_PC (10'h000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: instruction queue, one optional in-flight read, fetch pointer.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   data;
  } ent_t;

  ent_t          mq[$];
  logic          m_busy;
  logic          m_drop;
  logic [AW-1:0] m_addr;
  logic [AW-1:0] m_fetch_pc;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_busy     = 1'b0;
    m_drop     = 1'b0;
    m_addr     = '0;
    m_fetch_pc = '0;
  endfunction

  function automatic void model_step(input logic rv, input logic [AW-1:0] rpc,
                                     input logic ack, input logic rdy, input logic [31:0] d);
    logic deq;
    ent_t e;
    deq = rdy && (mq.size() > 0) && !rv;
    if (!m_busy) begin
      if (!rv && (mq.size() < DEPTH)) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = m_fetch_pc;
      end
    end else if (m_drop) begin
      if (ack) m_busy = 1'b0;
    end else if (rv) begin
      if (ack) m_busy = 1'b0;
      else     m_drop = 1'b1;
    end else if (ack) begin
      if (deq) begin
        void'(mq.pop_front());
        deq = 1'b0;
      end
      e.pc   = m_addr;
      e.data = d;
      mq.push_back(e);
      m_fetch_pc = AW'(m_addr + 4);
      if (mq.size() < DEPTH) m_addr = AW'(m_addr + 4);
      else                   m_busy = 1'b0;
    end
    if (deq) void'(mq.pop_front());
    if (rv) begin
      mq.delete();
      m_fetch_pc = rpc & ~AW'(3);
    end
  endfunction

  task automatic compare();
    logic          exp_v;
    logic [31:0]   exp_i;
    logic [AW-1:0] exp_pc;
    exp_v  = (mq.size() > 0);
    exp_i  = exp_v ? mq[0].data : NOP_W;
    exp_pc = exp_v ? mq[0].pc : '0;
    check("imem_req", 64'(imem_req), 64'(m_busy));
    if (m_busy) check("imem_addr", 64'(imem_addr), 64'(m_addr));
    check("inst_valid", 64'(inst_valid), 64'(exp_v));
    check("inst", 64'(inst), 64'(exp_i));
    check("inst_pc", 64'(inst_pc), 64'(exp_pc));
  endtask

  // Called at a falling edge: drive inputs, advance one rising edge, check at the next falling edge.
  task automatic cycle(input logic rv, input logic [AW-1:0] rpc, input logic ack, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ack       = ack;
    inst_ready     = rdy;
    imem_rdata     = ack ? mem_word(imem_addr) : $urandom;
    @(posedge clk);
    model_step(rv, rpc, ack, rdy, imem_rdata);
    @(negedge clk);
    compare();
  endtask

  // Asserts reset between clock edges to exercise its asynchronous effect.
  task automatic do_reset_async();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_req", 64'(imem_req), 64'(0));
    check("rst_async_addr", 64'(imem_addr), 64'(0));
    compare();
    @(posedge clk);
    @(negedge clk);
    compare();
    reset = 1'b0;
  endtask

  logic          r_rv;
  logic [AW-1:0] r_rpc;
  logic          r_ack;
  logic          r_rdy;

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_ack       = 1'b0;
    imem_rdata     = '0;
    inst_ready     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    check("rst_inst", 64'(inst), 64'(NOP_W));
    reset = 1'b0;

    // Ack tied high, decoder stalled: four fetches fill the queue, then requests stop.
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("c1_req", 64'(imem_req), 64'(1));
    check("c1_addr", 64'(imem_addr), 64'(10'h000));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("c2_valid", 64'(inst_valid), 64'(1));
    check("c2_addr", 64'(imem_addr), 64'(10'h004));
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0);
    check("full_idle", 64'(imem_req), 64'(0));
    cycle(1'b0, '0, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("refill_addr", 64'(imem_addr), 64'(10'h010));
    repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
    check("refill_stop", 64'(imem_req), 64'(0));

    // Redirect during a slow read: the stale response is dropped.
    cycle(1'b1, 10'h008, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("slow_addr", 64'(imem_addr), 64'(10'h008));
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 10'h103, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("drop_empty", 64'(inst_valid), 64'(0));
    cycle(1'b0, '0, 1'b0, 1'b0);
    check("redir_addr", 64'(imem_addr), 64'(10'h100));
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("redir_pc", 64'(inst_pc), 64'(10'h100));
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0);

    // Redirect together with ready and ack.
    cycle(1'b1, 10'h200, 1'b1, 1'b1);
    check("flush_valid", 64'(inst_valid), 64'(0));

    // Address wrap at the top of the space.
    cycle(1'b1, 10'h3FE, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("wrap_start", 64'(imem_addr), 64'(10'h3FC));
    cycle(1'b0, '0, 1'b1, 1'b1);
    check("wrap_next", 64'(imem_addr), 64'(10'h000));

    // Reset mid-request, then a stray ack.
    do_reset_async();
    cycle(1'b0, '0, 1'b1, 1'b0);
    check("stray_valid", 64'(inst_valid), 64'(0));
    check("restart_addr", 64'(imem_addr), 64'(10'h000));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      r_rv  = ($urandom_range(0, 15) == 0);
      r_rpc = ($urandom_range(0, 3) == 0) ? AW'(10'h3F0 + AW'($urandom_range(0, 15))) : AW'($urandom);
      r_ack = m_busy ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      r_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 599) == 0) do_reset_async();
      else cycle(r_rv, r_rpc, r_ack, r_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
